packet_buffer_arbiter: RTL and testbench
========================================

Name: packet_buffer_arbiter

Overview:
- Shares one packet-buffer memory port between NUM_REQ router controllers.
- Each controller raises a read or write request with a base address. The arbiter picks one winner by round-robin and holds its grant for a full packet burst of BURST_LEN beats.
- During the burst it drives the memory enable, write-enable and incrementing address, then pulses burst_done to the winner.
- It sits between the router controllers and the shared buffer RAM.

Parameters:
- NUM_REQ, 2, number of requesting controllers (min 2).
- ADDR_WIDTH, 10, buffer address width.
- BURST_LEN, 19, beats per packet burst (min 1).
- CNT_WIDTH, 5, beat counter width; must hold BURST_LEN-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_rd  in  NUM_REQ  per-requester read request, level.
- req_wr  in  NUM_REQ  per-requester write request, level.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester base address; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt_rd  out  NUM_REQ  read grant, one-hot or zero.
- gnt_wr  out  NUM_REQ  write grant, one-hot or zero.
- burst_done  out  NUM_REQ  one-cycle completion pulse to the winner.
- mem_en  out  1  memory access strobe, one per beat.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  ADDR_WIDTH  beat address.
- mem_last  out  1  high on the final beat of a burst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Outputs are Moore, decoded from registered state/winner/counter only. Inputs have no combinational path to outputs.
- Reset (async, any state including mid-burst):
  - state=IDLE, all outputs 0, beat counter 0, winner 0.
  - Round-robin pointer is set so requester 0 has top priority on the first arbitration.
  - No partial burst is resumed after reset.
- IDLE:
  - Requester i is active if req_rd[i] or req_wr[i] is set.
  - If any requester is active, the winner is the first active index searching upward (with wrap) from last_winner+1.
  - On that edge the arbiter latches the winner, direction (write wins if the winner asserts both) and base address, then goes to GRANT.
  - No active requester: stay in IDLE.
- GRANT (1 cycle):
  - gnt_wr[winner] or gnt_rd[winner]=1; mem_en=0.
  - Next state is BURST, with the counter cleared.
- BURST (exactly BURST_LEN cycles):
  - Grant stays high; mem_en=1; mem_we=direction.
  - mem_addr = base + counter, computed modulo 2^ADDR_WIDTH, so the address wraps (e.g. 0x3FF -> 0x000).
  - mem_last=1 when counter==BURST_LEN-1. Counter increments each cycle; at BURST_LEN-1 the next state is DONE.
  - Request inputs and req_addr are ignored (no abort). Dropping a request mid-burst does not shorten the burst.
- DONE (1 cycle):
  - Grants=0; mem_en=0; burst_done[winner]=1.
  - last_winner is updated to the winner; next state is IDLE.
- Timing: a request sampled in IDLE at edge T gives:
  - grant visible T+1..T+1+BURST_LEN;
  - first mem_en at T+2;
  - burst_done at T+2+BURST_LEN;
  - next possible grant at T+4+BURST_LEN.
  - Minimum arbitration period is BURST_LEN+3 cycles.
- Requester obligation: deassert its request in the burst_done cycle. A request still high when IDLE samples is treated as a new request, but round-robin still favours the other requesters.
- BURST_LEN=1: a single beat with mem_last=1 on it.
- Invariants:
  - At most one bit set across gnt_rd|gnt_wr.
  - mem_en implies exactly one grant is set.
  - burst_done is never coincident with mem_en.

Test Plan:
- Reset then idle: no requests for 10 cycles -> all outputs 0, busy=0.
- Single read: req_rd[0]=1, addr0=0x040, BURST_LEN=19 -> gnt_rd[0] at T+1; mem_en for 19 cycles with mem_we=0; mem_addr 0x040..0x052; mem_last on 0x052; burst_done[0] at T+21.
- Contention: req_wr[0] and req_rd[1] both held high from reset, never dropped -> grants alternate 0,1,0,1; period 22 cycles; no overlapping grants.
- Same-requester rd+wr: req_rd[1]=req_wr[1]=1, addr1=0x100 -> write burst (mem_we=1), gnt_wr[1]=1, gnt_rd[1]=0.
- Address wrap: req_wr[0], addr0=0x3F8 -> mem_addr 0x3F8..0x3FF then 0x000..0x00A, mem_last at 0x00A.
- Reset mid-burst: assert rst_n=0 at beat 7 of a read -> all outputs 0 immediately. After release with req_rd[1] high: grant goes to 1, burst restarts at beat 0 from addr1.

Source files
------------

// File: rtl/packet_buffer_arbiter.sv
// Round-robin arbiter sharing one packet-buffer memory port between NUM_REQ
// router controllers. A winner is granted for a full burst of BURST_LEN beats
// with an incrementing (wrapping) address, then receives a burst_done pulse.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for any read/write request, arbitrates round-robin
// GRANT  | grant asserted for one cycle before the first beat
// BURST  | BURST_LEN memory beats, grant held, requests ignored
// DONE   | grant dropped, burst_done pulsed, round-robin pointer advanced
//
// All outputs are registered; request inputs only influence the next state.
module packet_buffer_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int BURST_LEN  = 19,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_rd,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt_rd,
    output logic [NUM_REQ-1:0]            gnt_wr,
    output logic [NUM_REQ-1:0]            burst_done,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_last,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BURST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       last_winner;
    logic                   dir_wr;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic [CNT_WIDTH-1:0]   cnt;

    logic [NUM_REQ-1:0]     active;
    logic                   any_active;
    logic [IDX_W-1:0]       pick;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [NUM_REQ-1:0]     win_oh;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    int                     j;

    // Round-robin search upward from last_winner+1 with wrap; also one-hot decodes
    always_comb begin
        active     = req_rd | req_wr;
        any_active = 1'b0;
        pick       = '0;
        j          = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(last_winner) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any_active && active[j]) begin
                any_active = 1'b1;
                pick       = IDX_W'(j);
            end
        end
        pick_oh         = '0;
        pick_oh[pick]   = 1'b1;
        win_oh          = '0;
        win_oh[winner]  = 1'b1;
        cnt_nxt         = cnt + 1'b1;
    end

    // Sequencer: state, latched request context and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            winner      <= '0;
            last_winner <= IDX_W'(NUM_REQ - 1);
            dir_wr      <= 1'b0;
            base_addr   <= '0;
            cnt         <= '0;
            gnt_rd      <= '0;
            gnt_wr      <= '0;
            burst_done  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_last    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_active) begin
                        state     <= S_GRANT;
                        winner    <= pick;
                        dir_wr    <= req_wr[pick];
                        base_addr <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                        // write takes precedence when both directions are requested
                        gnt_wr    <= req_wr[pick] ? pick_oh : '0;
                        gnt_rd    <= req_wr[pick] ? '0 : pick_oh;
                        busy      <= 1'b1;
                    end
                end
                S_GRANT: begin
                    state    <= S_BURST;
                    cnt      <= '0;
                    mem_en   <= 1'b1;
                    mem_we   <= dir_wr;
                    mem_addr <= base_addr;
                    mem_last <= (BURST_LEN == 1);
                end
                S_BURST: begin
                    if (cnt == LAST_BEAT) begin
                        state      <= S_DONE;
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= '0;
                        mem_last   <= 1'b0;
                        gnt_rd     <= '0;
                        gnt_wr     <= '0;
                        burst_done <= win_oh;
                    end else begin
                        cnt      <= cnt_nxt;
                        // address wraps modulo 2^ADDR_WIDTH
                        mem_addr <= base_addr + ADDR_WIDTH'(cnt_nxt);
                        mem_last <= (cnt_nxt == LAST_BEAT);
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    burst_done  <= '0;
                    busy        <= 1'b0;
                    last_winner <= winner;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_buffer_arbiter.sv
// Scoreboard bench for packet_buffer_arbiter: stimulus pushes expected beats
// and completions, a negedge monitor pops and compares whatever the DUT emits.
module tb_packet_buffer_arbiter;

    localparam int NR = 2;
    localparam int AW = 10;
    localparam int BL = 19;
    localparam int CW = 5;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic          last;
        logic [NR-1:0] g_rd;
        logic [NR-1:0] g_wr;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_rd = '0;
    logic [NR-1:0]     req_wr = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR-1:0]     gnt_rd;
    logic [NR-1:0]     gnt_wr;
    logic [NR-1:0]     burst_done;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic              mem_last;
    logic              busy;

    beat_t beat_q[$];
    int    done_q[$];
    int    gnt_rise_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int beats_seen = 0;
    int last_gnt_cyc = -1;
    int last_en_cyc = -1;
    int last_done_cyc = -1;
    logic prev_gnt = 1'b0;
    logic prev_en = 1'b0;

    packet_buffer_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .BURST_LEN(BL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .gnt_rd(gnt_rd), .gnt_wr(gnt_wr),
        .burst_done(burst_done), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_last(mem_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // cycle stamp, advanced on every active edge
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: invariants, beat scoreboard, completion scoreboard, timing stamps
    always @(negedge clk) begin
        logic [NR-1:0] g;
        g = gnt_rd | gnt_wr;
        checks++;
        if (!$onehot0(g) || (mem_en && !$onehot(g)) || (mem_en && (|burst_done))) begin
            errors++;
            $display("FAIL invariant cyc=%0d gnt_rd=%b gnt_wr=%b mem_en=%b burst_done=%b",
                     cyc, gnt_rd, gnt_wr, mem_en, burst_done);
        end
        if ((|g) && !prev_gnt) begin
            gnt_rise_q.push_back(cyc);
            last_gnt_cyc = cyc;
        end
        if (mem_en && !prev_en) last_en_cyc = cyc;
        prev_gnt = |g;
        prev_en  = mem_en;
        if (mem_en) begin
            checks++;
            if (beat_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat cyc=%0d addr=%h", cyc, mem_addr);
            end else begin
                beat_t e;
                e = beat_q.pop_front();
                if (mem_addr !== e.addr || mem_we !== e.we || mem_last !== e.last ||
                    gnt_rd !== e.g_rd || gnt_wr !== e.g_wr || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL beat cyc=%0d got addr=%h we=%b last=%b grd=%b gwr=%b busy=%b exp addr=%h we=%b last=%b grd=%b gwr=%b busy=1",
                             cyc, mem_addr, mem_we, mem_last, gnt_rd, gnt_wr, busy,
                             e.addr, e.we, e.last, e.g_rd, e.g_wr);
                end
            end
            beats_seen++;
        end
        if (|burst_done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done cyc=%0d burst_done=%b", cyc, burst_done);
            end else begin
                int idx;
                logic [NR-1:0] exp_d;
                idx   = done_q.pop_front();
                exp_d = '0;
                exp_d[idx] = 1'b1;
                if (burst_done !== exp_d || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL burst_done cyc=%0d got=%b busy=%b exp=%b busy=1",
                             cyc, burst_done, busy, exp_d);
                end
            end
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int idx, input logic [AW-1:0] a);
        req_addr[idx*AW +: AW] = a;
    endtask

    // expected beats and completion for one burst
    task automatic push_burst(input int idx, input logic wr, input logic [AW-1:0] base);
        for (int b = 0; b < BL; b++) begin
            beat_t e;
            e.addr = base + AW'(b);
            e.we   = wr;
            e.last = (b == BL - 1);
            e.g_rd = '0;
            e.g_wr = '0;
            if (wr) e.g_wr[idx] = 1'b1;
            else    e.g_rd[idx] = 1'b1;
            beat_q.push_back(e);
        end
        done_q.push_back(idx);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            if (done_cnt >= target) return;
            tick();
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s done_cnt=%0d required=%0d", name, done_cnt, target);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({gnt_rd, gnt_wr, burst_done, mem_en, mem_we, mem_addr, mem_last, busy} !== '0) begin
            errors++;
            $display("FAIL %s outputs not zero: grd=%b gwr=%b done=%b en=%b we=%b addr=%h last=%b busy=%b",
                     name, gnt_rd, gnt_wr, burst_done, mem_en, mem_we, mem_addr, mem_last, busy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        int s;
        int target;

        // reset, then idle with no requests
        do_reset();
        for (int n = 0; n < 10; n++) begin
            tick();
            check_outputs_zero("idle");
        end

        // single read from requester 0
        set_addr(0, 10'h040);
        push_burst(0, 1'b0, 10'h040);
        c = cyc;
        req_rd[0] = 1'b1;
        target = done_cnt + 1;
        wait_done(target, 60, "single_read");
        req_rd[0] = 1'b0;
        check_int("read_grant_latency", last_gnt_cyc, c + 1);
        check_int("read_first_beat", last_en_cyc, c + 2);
        check_int("read_done_time", last_done_cyc, c + 2 + BL);
        repeat (3) tick();

        // requester 1 asserts both directions: write wins
        set_addr(1, 10'h100);
        push_burst(1, 1'b1, 10'h100);
        req_rd[1] = 1'b1;
        req_wr[1] = 1'b1;
        target = done_cnt + 1;
        wait_done(target, 60, "rd_wr_same");
        req_rd[1] = 1'b0;
        req_wr[1] = 1'b0;
        repeat (3) tick();

        // write burst whose address wraps past the top of the buffer
        set_addr(0, 10'h3F8);
        push_burst(0, 1'b1, 10'h3F8);
        req_wr[0] = 1'b1;
        target = done_cnt + 1;
        wait_done(target, 60, "addr_wrap");
        req_wr[0] = 1'b0;
        repeat (3) tick();

        // contention from reset: grants alternate 0,1,0,1 every BL+3 cycles
        s = gnt_rise_q.size();
        set_addr(0, 10'h080);
        set_addr(1, 10'h2F0);
        req_wr = 2'b01;
        req_rd = 2'b10;
        push_burst(0, 1'b1, 10'h080);
        push_burst(1, 1'b0, 10'h2F0);
        push_burst(0, 1'b1, 10'h080);
        push_burst(1, 1'b0, 10'h2F0);
        do_reset();
        target = done_cnt + 4;
        wait_done(target, 4 * (BL + 3) + 20, "contention");
        req_wr = '0;
        req_rd = '0;
        check_int("contention_grant_count", gnt_rise_q.size() - s, 4);
        if (gnt_rise_q.size() >= s + 4) begin
            for (int i = 0; i < 3; i++) begin
                check_int("contention_period", gnt_rise_q[s+i+1] - gnt_rise_q[s+i], BL + 3);
            end
        end
        repeat (3) tick();

        // reset in the middle of a read burst, then a fresh burst for requester 1
        set_addr(0, 10'h200);
        set_addr(1, 10'h155);
        push_burst(0, 1'b0, 10'h200);
        s = beats_seen;
        req_rd[0] = 1'b1;
        for (int n = 0; n < 60 && beats_seen < s + 7; n++) tick();
        check_int("beats_before_reset", beats_seen - s, 7);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_burst_reset");
        beat_q.delete();
        done_q.delete();
        tick();
        req_rd = 2'b10;
        push_burst(1, 1'b0, 10'h155);
        rst_n = 1'b1;
        target = done_cnt + 1;
        wait_done(target, 60, "after_reset");
        req_rd = '0;
        repeat (3) tick();
        check_outputs_zero("final_idle");

        check_int("beat_queue_empty", beat_q.size(), 0);
        check_int("done_queue_empty", done_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
